vid_attrib_pipe: RTL and testbench

//  Pipelined, parametrised attribute/colour controller for the CGA/Tandy video path.

---
 rtl/vid_attrib_pipe.sv | 192 +++++++++++++++++++
 tb/tb_vid_attrib_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_attrib_pipe.sv
// CGA/Tandy attribute/colour pipeline: blink generation, colour select, shutter, aligned syncs.
// Optional 16-entry writable output palette enabled with `define ATTRIB_PALETTE_EN.
module vid_attrib_pipe #(
  parameter int PIX_W     = 4,
  parameter int BLINK_DIV = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       att_byte,
  input  logic [7:0]       color_reg,
  input  logic             grph_mode,
  input  logic             bw_mode,
  input  logic             mode_640,
  input  logic             tandy_16_mode,
  input  logic             blink_enabled,
  input  logic             display_enable,
  input  logic             cursor,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             pix_in,
  input  logic             c0,
  input  logic             c1,
  input  logic             pix_640,
  input  logic [3:0]       pix_tandy,
  input  logic             pal_wr,
  input  logic [3:0]       pal_addr,
  input  logic [PIX_W-1:0] pal_data,
  output logic [PIX_W-1:0] pix_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic             blink_phase
);

`ifdef ATTRIB_PALETTE_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef struct packed {
    logic [7:0] att;
    logic [5:0] color;
    logic       grph;
    logic       bw;
    logic       m640;
    logic       tandy;
    logic       blink_en;
    logic       de;
    logic       cursor;
    logic       hs;
    logic       vs;
    logic       pix;
    logic       c0;
    logic       c1;
    logic       p640;
    logic [3:0] tpix;
  } s1_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  s1_t                 s1_d, s1;
  sync_t               sync_in;
  sync_t [STAGES:1]    sync_pipe;
  logic [3:0]          idx, bg;
  logic                alpha, shut;
  logic                vs_q, char_blink;
  logic [CNT_W-1:0]    frame_cnt;

  wire unused_color = ^color_reg[7:6];

  // ---------------- blink generator ----------------
  wire vs_rise = vsync & ~vs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q        <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      char_blink  <= 1'b0;
    end else begin
      vs_q <= vsync;
      if (vs_rise) begin
        if (frame_cnt == CNT_W'(BLINK_DIV - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
          // character blink runs at half the cursor rate
          if (!blink_phase) char_blink <= ~char_blink;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- S1: input capture ----------------
  always_comb begin
    s1_d          = '0;
    s1_d.att      = att_byte;
    s1_d.color    = color_reg[5:0];
    s1_d.grph     = grph_mode;
    s1_d.bw       = bw_mode;
    s1_d.m640     = mode_640;
    s1_d.tandy    = tandy_16_mode;
    s1_d.blink_en = blink_enabled;
    s1_d.de       = display_enable;
    s1_d.cursor   = cursor;
    s1_d.hs       = hsync;
    s1_d.vs       = vsync;
    s1_d.pix      = pix_in;
    s1_d.c0       = c0;
    s1_d.c1       = c1;
    s1_d.p640     = pix_640;
    s1_d.tpix     = pix_tandy;
  end

  assign sync_in = {hsync, vsync, display_enable};

  // ---------------- S2: colour index and shutter ----------------
  always_comb begin
    bg    = s1.blink_en ? {1'b0, s1.att[6:4]} : s1.att[7:4];
    alpha = (s1.pix & ~(s1.blink_en & s1.att[7] & ~s1.cursor & char_blink))
          | (s1.cursor & blink_phase);
    if (!s1.de)
      idx = s1.color[3:0];
    else if (s1.grph && s1.tandy)
      idx = s1.tpix;
    else if (s1.grph && !s1.m640 && (s1.c0 || s1.c1))
      idx = {s1.color[4], s1.c1, s1.c0, (s1.bw ? s1.c0 : s1.color[5])};
    else if (s1.grph)
      idx = s1.color[3:0];
    else
      idx = alpha ? s1.att[3:0] : bg;
    // blanked during sync, and in 640 mode wherever the mono dot is off
    shut = s1.hs | s1.vs | (s1.m640 & ~(s1.de & s1.p640));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '0;
      sync_pipe <= '0;
    end else begin
      s1        <= s1_d;
      sync_pipe <= {sync_pipe[STAGES-1:1], sync_in};
    end
  end

  assign {hsync_out, vsync_out, de_out} = sync_pipe[STAGES];

`ifdef ATTRIB_PALETTE_EN
  logic [3:0]       s2_idx;
  logic             s2_shut;
  logic [PIX_W-1:0] pal [16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_idx  <= '0;
      s2_shut <= 1'b0;
    end else begin
      s2_idx  <= idx;
      s2_shut <= shut;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) pal[i] <= PIX_W'(i);
    end else if (pal_wr) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // ---------------- S3: palette lookup (reads pre-write entry) ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_out <= '0;
    else          pix_out <= s2_shut ? '0 : pal[s2_idx];
  end
`else
  wire unused_pal = ^{pal_wr, pal_addr, pal_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_out <= '0;
    else          pix_out <= shut ? '0 : PIX_W'(idx);
  end
`endif

endmodule

// File: tb/tb_vid_attrib_pipe.sv
// Randomised + directed bench for vid_attrib_pipe against a frame-count based reference model.
module tb_vid_attrib_pipe;
  localparam int PIX_W     = 6;
  localparam int BLINK_DIV = 4;
`ifdef ATTRIB_PALETTE_EN
  localparam int LAT = 3;
  localparam bit PAL = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit PAL = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]       att;
    logic [7:0]       color;
    logic             grph, bw, m640, tandy, blink_en, de, cursor, hs, vs, pix, c0, c1, p640;
    logic [3:0]       tpix;
    logic             wr;
    logic [3:0]       addr;
    logic [PIX_W-1:0] data;
  } vec_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             hs, vs, de;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] att_byte, color_reg;
  logic grph_mode, bw_mode, mode_640, tandy_16_mode, blink_enabled, display_enable;
  logic cursor, hsync, vsync, pix_in, c0, c1, pix_640, pal_wr;
  logic [3:0] pix_tandy, pal_addr;
  logic [PIX_W-1:0] pal_data, pix_out;
  logic hsync_out, vsync_out, de_out, blink_phase;

  vid_attrib_pipe #(.PIX_W(PIX_W), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .att_byte(att_byte), .color_reg(color_reg),
    .grph_mode(grph_mode), .bw_mode(bw_mode), .mode_640(mode_640),
    .tandy_16_mode(tandy_16_mode), .blink_enabled(blink_enabled),
    .display_enable(display_enable), .cursor(cursor), .hsync(hsync), .vsync(vsync),
    .pix_in(pix_in), .c0(c0), .c1(c1), .pix_640(pix_640), .pix_tandy(pix_tandy),
    .pal_wr(pal_wr), .pal_addr(pal_addr), .pal_data(pal_data), .pix_out(pix_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int pulses = 0;
  logic prev_vs = 1'b0;
  logic [PIX_W-1:0] pal_m [16];
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_idx(input vec_t v, input bit ph, input bit cb);
    bit dot;
    if (!v.de) return v.color[3:0];
    if (v.grph) begin
      if (v.tandy) return v.tpix;
      if (!v.m640 && (v.c0 || v.c1)) return {v.color[4], v.c1, v.c0, (v.bw ? v.c0 : v.color[5])};
      return v.color[3:0];
    end
    dot = v.pix;
    if (v.blink_en && v.att[7] && !v.cursor && cb) dot = 1'b0;
    if (v.cursor && ph) dot = 1'b1;
    if (dot) return v.att[3:0];
    return v.blink_en ? {1'b0, v.att[6:4]} : v.att[7:4];
  endfunction

  task automatic model_reset();
    q.delete();
    pulses  = 0;
    prev_vs = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = PIX_W'(i);
  endtask

  task automatic apply(input vec_t v);
    att_byte = v.att; color_reg = v.color; grph_mode = v.grph; bw_mode = v.bw;
    mode_640 = v.m640; tandy_16_mode = v.tandy; blink_enabled = v.blink_en;
    display_enable = v.de; cursor = v.cursor; hsync = v.hs; vsync = v.vs;
    pix_in = v.pix; c0 = v.c0; c1 = v.c1; pix_640 = v.p640; pix_tandy = v.tpix;
    pal_wr = v.wr; pal_addr = v.addr; pal_data = v.data;
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    int k;
    bit shut;
    @(negedge clk);
    apply(v);
    if (reset_n) begin
      if (PAL && v.wr) pal_m[v.addr] = v.data;
      if (v.vs && !prev_vs) pulses++;
      prev_vs = v.vs;
    end
    k = pulses / BLINK_DIV;
    if (reset_n) begin
      shut = v.hs | v.vs | (v.m640 & ~(v.de & v.p640));
      e.hs = v.hs; e.vs = v.vs; e.de = v.de;
      if (shut)     e.pix = '0;
      else if (PAL) e.pix = pal_m[ref_idx(v, (k % 2) == 1, (((k + 1) / 2) % 2) == 1)];
      else          e.pix = PIX_W'(ref_idx(v, (k % 2) == 1, (((k + 1) / 2) % 2) == 1));
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (!reset_n) begin
      chk("rst_pix", pix_out, 0);
      chk("rst_sync", {hsync_out, vsync_out, de_out}, 0);
      chk("rst_phase", blink_phase, 0);
    end else begin
      if (q.size() == LAT) begin
        e = q.pop_front();
        chk("pix", pix_out, e.pix);
        chk("hs", hsync_out, e.hs);
        chk("vs", vsync_out, e.vs);
        chk("de", de_out, e.de);
      end
      chk("blink_phase", blink_phase, k % 2);
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    v = '0;
    v.att = 8'($urandom); v.color = 8'($urandom);
    v.grph = 1'($urandom); v.bw = 1'($urandom);
    v.m640 = ($urandom % 4) == 0; v.tandy = ($urandom % 3) == 0;
    v.blink_en = 1'($urandom); v.de = ($urandom % 4) != 0;
    v.cursor = ($urandom % 5) == 0; v.hs = ($urandom % 8) == 0; v.vs = ($urandom % 6) == 0;
    v.pix = 1'($urandom); v.c0 = 1'($urandom); v.c1 = 1'($urandom); v.p640 = 1'($urandom);
    v.tpix = 4'($urandom);
    v.wr = PAL ? 1'b0 : 1'($urandom);
    v.addr = 4'($urandom); v.data = PIX_W'($urandom);
    return v;
  endfunction

  function automatic vec_t text_vec(input logic [7:0] att, input logic blink_en);
    vec_t v;
    v = '0;
    v.att = att; v.blink_en = blink_en; v.de = 1'b1; v.pix = 1'b1;
    return v;
  endfunction

  // palette write framed by sync-blanked pixels so in-flight lookups are don't-care
  task automatic pal_write(input logic [3:0] addr, input logic [PIX_W-1:0] data);
    vec_t v;
    v = '0; v.hs = 1'b1;
    step(v);
    v.wr = 1'b1; v.addr = addr; v.data = data;
    step(v);
  endtask

  initial begin
    vec_t v;
    model_reset();
    v = '0;
    apply(v);

    // reset held, random inputs: all outputs stay 0
    for (int i = 0; i < 6; i++) begin
      v = rnd_vec(); v.wr = 1'b0;
      step(v);
    end
    reset_n = 1'b1;

    // text attribute 0x1E, exact latency
    v = '0;
    for (int i = 0; i < 3; i++) step(v);
    for (int i = 0; i < LAT; i++) step(text_vec(8'h1E, 1'b0));
    chk("t1_text", pix_out, 'hE);

    // blink: phase and char blink over 16 vsync pulses
    for (int p = 1; p <= 16; p++) begin
      v = text_vec(8'h9E, 1'b1); v.vs = 1'b1;
      step(v);
      for (int i = 0; i < 3; i++) step(text_vec(8'h9E, 1'b1));
      if (p == 4)  chk("t2_phase4", blink_phase, 1);
      if (p == 8)  chk("t2_phase8", blink_phase, 0);
      if (p == 2)  chk("t2_pix2", pix_out, 'hE);
      if (p == 6)  chk("t2_pix6", pix_out, 'h1);
    end

    // graphics 320 mode
    v = '0; v.grph = 1'b1; v.de = 1'b1; v.color = 8'h20; v.c1 = 1'b1;
    for (int i = 0; i < LAT; i++) step(v);
    chk("t3_320", pix_out, 'h5);
    v.c1 = 1'b0;
    for (int i = 0; i < LAT; i++) step(v);
    chk("t3_bgcol", pix_out, 'h0);
    v.de = 1'b0; v.color = 8'h09;
    for (int i = 0; i < LAT; i++) step(v);
    chk("t3_overscan", pix_out, 'h9);

    // palette entry 5 -> 0xC, entry 0 -> all ones (shutter must still give 0)
    pal_write(4'd5, PIX_W'('hC));
    pal_write(4'd0, '1);
    v = '0; v.grph = 1'b1; v.de = 1'b1; v.color = 8'h20; v.c1 = 1'b1;
    for (int i = 0; i < LAT; i++) step(v);
    chk("t4_pal5", pix_out, PAL ? 'hC : 'h5);
    for (int i = 0; i < LAT; i++) step(text_vec(8'h1E, 1'b0));
    chk("t4_pal_e", pix_out, 'hE);

    // shutter
    v = text_vec(8'h1E, 1'b0); v.hs = 1'b1;
    for (int i = 0; i < LAT; i++) step(v);
    chk("t5_hs_pix", pix_out, 0);
    chk("t5_hs_out", hsync_out, 1);
    v = text_vec(8'h1E, 1'b0); v.m640 = 1'b1;
    for (int i = 0; i < LAT; i++) step(v);
    chk("t5_640_off", pix_out, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) step(rnd_vec());

    // asynchronous reset mid-line
    for (int i = 0; i < LAT + 1; i++) step(text_vec(8'h1E, 1'b0));
    chk("t6_pre", pix_out, 'hE);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_pix", pix_out, 0);
    chk("t6_async_phase", blink_phase, 0);
    model_reset();
    for (int i = 0; i < 3; i++) step(text_vec(8'h1E, 1'b0));
    reset_n = 1'b1;
    chk("t6_phase0", blink_phase, 0);
    for (int p = 0; p < BLINK_DIV; p++) begin
      v = text_vec(8'h1E, 1'b0); v.vs = 1'b1;
      step(v);
      step(text_vec(8'h1E, 1'b0));
    end
    chk("t6_restart", blink_phase, 1);
    for (int i = 0; i < 200; i++) step(rnd_vec());

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
